// File: rtl/mtc_slot_scheduler.sv
// mtc_slot_scheduler: buffers N_IN candidate MTC lanes in small FIFOs and
// drains up to N_OUT of them per clock onto the output slots, round-robin.
// Packets that arrive at a full, un-popped lane are dropped and counted.
module mtc_slot_scheduler #(
   parameter int MTC_WIDTH  = 16,
   parameter int N_IN       = 3,
   parameter int N_OUT      = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 srst,
   input  logic [MTC_WIDTH-1:0] mtc_in     [N_IN],
   output logic [MTC_WIDTH-1:0] mtc_out    [N_OUT],
   output logic [N_IN-1:0]      lane_full,
   output logic [CNT_WIDTH-1:0] drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int DW = $clog2(N_IN + 1);

   logic                 clear;
   logic [MTC_WIDTH-1:0] mem        [N_IN][FIFO_DEPTH];
   logic [AW-1:0]        rd_ptr     [N_IN];
   logic [AW-1:0]        wr_ptr     [N_IN];
   logic [CW-1:0]        count      [N_IN];
   logic [CW-1:0]        count_next [N_IN];
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        rr_next;
   logic [N_IN-1:0]      grant;
   logic [N_IN-1:0]      push_ok;
   logic [N_IN-1:0]      drop;
   logic [MTC_WIDTH-1:0] slot_data  [N_OUT];
   logic [DW-1:0]        n_drop;
   logic [CNT_WIDTH:0]   drop_sum;
   int                   n_grant;
   int                   scan_idx;

   assign clear = rst | srst;

   // Round-robin scan from rr_ptr over pre-push occupancy; the k-th granted lane's head feeds slot k
   always_comb begin
      grant    = '0;
      rr_next  = rr_ptr;
      n_grant  = 0;
      scan_idx = 0;
      for (int s = 0; s < N_OUT; s++) begin
         slot_data[s] = '0;
      end
      for (int k = 0; k < N_IN; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= N_IN) begin
            scan_idx = scan_idx - N_IN;
         end
         for (int i = 0; i < N_IN; i++) begin
            if (i == scan_idx && count[i] != '0 && n_grant < N_OUT) begin
               grant[i] = 1'b1;
               for (int s = 0; s < N_OUT; s++) begin
                  if (s == n_grant) begin
                     slot_data[s] = mem[i][rd_ptr[i]];
                  end
               end
               n_grant = n_grant + 1;
               rr_next = (i == N_IN - 1) ? '0 : PW'(i + 1);
            end
         end
      end
   end

   // A valid word is accepted when its lane has room or is being popped this cycle; otherwise it is a drop
   always_comb begin
      push_ok = '0;
      drop    = '0;
      n_drop  = '0;
      for (int i = 0; i < N_IN; i++) begin
         push_ok[i]    = mtc_in[i][MTC_WIDTH-1] && ((count[i] != CW'(FIFO_DEPTH)) || grant[i]);
         drop[i]       = mtc_in[i][MTC_WIDTH-1] && !push_ok[i];
         count_next[i] = count[i] + CW'(push_ok[i]) - CW'(grant[i]);
         n_drop        = n_drop + DW'(drop[i]);
      end
      drop_sum = {1'b0, drop_count} + (CNT_WIDTH + 1)'(n_drop);
   end

   // Control state: pointers, occupancy, full flags, saturating drop counter and registered output slots
   always_ff @(posedge clk) begin
      if (clear) begin
         rr_ptr     <= '0;
         drop_count <= '0;
         lane_full  <= '0;
         for (int i = 0; i < N_IN; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         for (int s = 0; s < N_OUT; s++) begin
            mtc_out[s] <= '0;
         end
      end else begin
         rr_ptr     <= rr_next;
         drop_count <= (drop_sum > {1'b0, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}}
                                                              : drop_sum[CNT_WIDTH-1:0];
         for (int i = 0; i < N_IN; i++) begin
            count[i]     <= count_next[i];
            lane_full[i] <= (count_next[i] == CW'(FIFO_DEPTH));
            if (push_ok[i]) begin
               wr_ptr[i] <= wr_ptr[i] + AW'(1);
            end
            if (grant[i]) begin
               rd_ptr[i] <= rd_ptr[i] + AW'(1);
            end
         end
         for (int s = 0; s < N_OUT; s++) begin
            mtc_out[s] <= slot_data[s];
         end
      end
   end

   // Lane storage; the head is read combinationally before this edge so a full lane can pop and push together
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_IN; i++) begin
         if (!clear && push_ok[i]) begin
            mem[i][wr_ptr[i]] <= mtc_in[i];
         end
      end
   end

endmodule
